// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-word capture stage.
// No logic; no latency. Build option SIPO_PARIDAD_EN appends an even-parity bit to each word.
// Backpressure: not applicable.
package sipo_pkg;

    typedef enum logic {
        RECIBE  = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

`ifdef SIPO_PARIDAD_EN
    localparam int BITS_EXTRA = 1;
`else
    localparam int BITS_EXTRA = 0;
`endif

    function automatic int ancho_contador(input int n);
        return $clog2(n + 1);
    endfunction

    // Serial bits that make up one word on the link, parity included when enabled.
    function automatic int bits_por_palabra(input int n);
        return n + BITS_EXTRA;
    endfunction

endpackage

// File: rtl/contador_bits.sv
// Modulo-M up-counter with synchronous clear and count enable; flags the last count.
// Latency: count updates on the enabled edge; the terminal flag is combinational from the count.
// Backpressure: none; holds its value while the enable is low.
module contador_bits #(
    parameter int M = 4,
    parameter int W = $clog2(M + 1)
) (
    input  logic         reloj,
    input  logic         borrar,
    input  logic         habilitar,
    output logic [W-1:0] cuenta,
    output logic         terminal
);

    assign terminal = (cuenta == W'(M - 1));

    always_ff @(posedge reloj) begin
        if (borrar) begin
            cuenta <= '0;
        end else if (habilitar) begin
            cuenta <= terminal ? '0 : cuenta + W'(1);
        end
    end

endmodule

// File: rtl/reg_sipo_captura.sv
// Serial-in/parallel-out capture: shifts N bits MSB first, then offers the word with valid/ready.
// Latency: palabra_valida rises 1 clock after the last serial bit; build option SIPO_PARIDAD_EN adds a parity bit and error flag.
// Backpressure: listo_serie drops while a word waits, so serial bits stall until listo_sig takes it.
module reg_sipo_captura
    import sipo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         reloj,
    input  logic         reset_despeje,
    input  logic         bit_valido,
    input  logic         dato_serie,
    output logic         listo_serie,
    output logic [N-1:0] palabra,
    output logic         palabra_valida,
    input  logic         listo_sig,
    output logic         error_paridad
);

    localparam int CW               = ancho_contador(N);
    localparam int BITS_POR_PALABRA = bits_por_palabra(N);

    estado_t        estado, estado_sig;
    logic           acepta;
    logic           ultimo;
    logic [CW-1:0]  cuenta;
    logic [N-1:0]   sr;

    assign acepta = (estado == RECIBE) && bit_valido;

    contador_bits #(
        .M (BITS_POR_PALABRA),
        .W (CW)
    ) u_contador (
        .reloj     (reloj),
        .borrar    (reset_despeje),
        .habilitar (acepta),
        .cuenta    (cuenta),
        .terminal  (ultimo)
    );

    always_ff @(posedge reloj) begin
        if (reset_despeje) begin
            estado <= RECIBE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Handshake outputs decode only the registered state, never the inputs.
    always_comb begin
        estado_sig     = estado;
        listo_serie    = 1'b0;
        palabra_valida = 1'b0;
        case (estado)
            RECIBE: begin
                listo_serie = 1'b1;
                if (acepta && ultimo) begin
                    estado_sig = ENTREGA;
                end
            end
            ENTREGA: begin
                palabra_valida = 1'b1;
                if (listo_sig) begin
                    estado_sig = RECIBE;
                end
            end
            default: estado_sig = RECIBE;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (reset_despeje) begin
            sr      <= '0;
            palabra <= '0;
        end else if (acepta) begin
            sr <= {sr[N-2:0], dato_serie};
            if (ultimo) begin
`ifdef SIPO_PARIDAD_EN
                // The final bit is parity, so the data word is already complete in sr.
                palabra <= sr;
`else
                palabra <= {sr[N-2:0], dato_serie};
`endif
            end
        end
    end

`ifdef SIPO_PARIDAD_EN
    logic error_q;

    always_ff @(posedge reloj) begin
        if (reset_despeje) begin
            error_q <= 1'b0;
        end else if (acepta && ultimo) begin
            error_q <= (^sr) ^ dato_serie;
        end
    end

    assign error_paridad = error_q;
`else
    assign error_paridad = 1'b0;
`endif

    a_cuenta_en_rango : assert property (@(posedge reloj) disable iff (reset_despeje)
        cuenta < CW'(BITS_POR_PALABRA));

endmodule

// File: tb/tb_reg_sipo_captura.sv
// Bench for reg_sipo_captura: directed cases plus random traffic against a queue-based link model.
// A monitor on the falling edge compares every cycle and pops the scoreboard on each handshake.
module tb_reg_sipo_captura;

    localparam int N = 4;
`ifdef SIPO_PARIDAD_EN
    localparam int BPW = N + 1;
`else
    localparam int BPW = N;
`endif

    typedef struct packed {
        logic [N-1:0] w;
        logic         e;
    } esperado_t;

    logic         reloj = 1'b0;
    logic         reset_despeje;
    logic         bit_valido;
    logic         dato_serie;
    logic         listo_serie;
    logic [N-1:0] palabra;
    logic         palabra_valida;
    logic         listo_sig;
    logic         error_paridad;

    reg_sipo_captura #(.N(N)) dut (
        .reloj          (reloj),
        .reset_despeje  (reset_despeje),
        .bit_valido     (bit_valido),
        .dato_serie     (dato_serie),
        .listo_serie    (listo_serie),
        .palabra        (palabra),
        .palabra_valida (palabra_valida),
        .listo_sig      (listo_sig),
        .error_paridad  (error_paridad)
    );

    always #5 reloj = ~reloj;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    bit armed    = 1'b0;

    // Reference model: a word is pending or not; serial bits collect in a list.
    bit           m_pend    = 1'b0;
    logic [N-1:0] m_palabra = '0;
    bit           m_err     = 1'b0;
    bit           m_bits[$];
    esperado_t    sb[$];

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nombre, act, req, $time);
        end
    endtask

    task automatic model_update();
        logic [N-1:0] w;
        bit           p;
        if (reset_despeje) begin
            m_pend    = 1'b0;
            m_palabra = '0;
            m_err     = 1'b0;
            m_bits.delete();
            sb.delete();
        end else if (!m_pend) begin
            if (bit_valido) begin
                m_bits.push_back(dato_serie);
                if (m_bits.size() == BPW) begin
                    w = '0;
                    p = 1'b0;
                    for (int i = 0; i < N; i++) w = (w << 1) | N'(m_bits[i]);
                    for (int i = 0; i < BPW; i++) p = p ^ m_bits[i];
                    m_palabra = w;
                    m_err     = (BPW == N) ? 1'b0 : p;
                    sb.push_back('{w: w, e: m_err});
                    m_pend = 1'b1;
                    m_bits.delete();
                end
            end
        end else if (listo_sig) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit bv, input bit d, input bit ls);
        reset_despeje = r;
        bit_valido    = bv;
        dato_serie    = d;
        listo_sig     = ls;
        @(posedge reloj);
        model_update();
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit gaps, input bit ls);
        for (int i = N - 1; i >= 0; i--) begin
            if (gaps) step(1'b0, 1'b0, ~w[i], ls);
            step(1'b0, 1'b1, w[i], ls);
        end
`ifdef SIPO_PARIDAD_EN
        if (gaps) step(1'b0, 1'b0, 1'b0, ls);
        step(1'b0, 1'b1, ^w, ls);
`endif
    endtask

    always @(negedge reloj) begin
        esperado_t e;
        if (armed) begin
            chk("palabra_valida", 32'(palabra_valida), 32'(m_pend));
            chk("listo_serie", 32'(listo_serie), 32'(!m_pend));
            chk("palabra", 32'(palabra), 32'(m_palabra));
            chk("error_paridad", 32'(error_paridad), 32'(m_err));
            if (palabra_valida && listo_sig && !reset_despeje) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    chk("sb_palabra", 32'(palabra), 32'(e.w));
                    chk("sb_error", 32'(error_paridad), 32'(e.e));
                end
            end
        end
    end

    initial begin
        int p0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        armed = 1'b1;
        chk("reset_palabra", 32'(palabra), 32'h0);
        chk("reset_valida", 32'(palabra_valida), 32'h0);
        chk("reset_error", 32'(error_paridad), 32'h0);
        chk("reset_listo", 32'(listo_serie), 32'h1);

        // Consecutive bits 1,0,1,1
        send_word(4'hB, 1'b0, 1'b1);
        chk("t1_valida", 32'(palabra_valida), 32'h1);
        chk("t1_palabra", 32'(palabra), 32'hB);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_valida_baja", 32'(palabra_valida), 32'h0);

        // Idle cycles between bits must not shift
        send_word(4'hB, 1'b1, 1'b1);
        chk("t2_palabra", 32'(palabra), 32'hB);
        chk("t2_valida", 32'(palabra_valida), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Stalled downstream while serial bits keep arriving
        send_word(4'h6, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, k[0], 1'b0);
            chk("t3_valida", 32'(palabra_valida), 32'h1);
            chk("t3_palabra", 32'(palabra), 32'h6);
            chk("t3_listo", 32'(listo_serie), 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_transfer", 32'(palabra_valida), 32'h0);
        send_word(4'h9, 1'b0, 1'b1);
        chk("t3_siguiente", 32'(palabra), 32'h9);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word discards the partial bits
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_valida_reset", 32'(palabra_valida), 32'h0);
        chk("t4_palabra_reset", 32'(palabra), 32'h0);
        send_word(4'h3, 1'b0, 1'b1);
        chk("t4_palabra", 32'(palabra), 32'h3);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back words
        p0 = pops;
        send_word(4'hA, 1'b0, 1'b1);
        chk("t5_palabra_a", 32'(palabra), 32'hA);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(4'h5, 1'b0, 1'b1);
        chk("t5_palabra_5", 32'(palabra), 32'h5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_pulsos", 32'(pops - p0), 32'd2);

`ifdef SIPO_PARIDAD_EN
        for (int i = N - 1; i >= 0; i--) step(1'b0, 1'b1, (i != 2), 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t6_paridad_ok", 32'(error_paridad), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = N - 1; i >= 0; i--) step(1'b0, 1'b1, (i != 2), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t6_paridad_err", 32'(error_paridad), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`else
        send_word(4'hF, 1'b0, 1'b1);
        chk("t6_sin_paridad", 32'(error_paridad), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 60) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sb_vacio", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
